// File: rtl/cla_wide_add_seq.sv
// Purpose : multi-cycle W-bit add/subtract. One shared 16-bit CLA processes the operand
//           one slice per cycle, least-significant slice first, with the carry registered
//           between slices.
// Latency : start accepted in cycle T -> done pulse in cycle T+N_WORDS+1.
// Backpressure: start is accepted only while idle (busy=0). Starts seen during RUN/DONE
//           are dropped, not queued.
// Ports   : clk, reset (sync, active-high) | start, sub, cin, a[W], b[W] request side |
//           busy, done, sum[W], cout, ovf result side (all registered).

// 16-bit carry-lookahead adder: four 4-bit lookahead groups plus a second lookahead
// level across the groups. Every carry is a two-level function of x, y and c0.
module Cla_16 (
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   input  logic        i_c0,
   output logic [15:0] o_s,
   output logic        o_c16,
   output logic        o_g,
   output logic        o_p
);

   logic [15:0] w_g;    // bit generate
   logic [15:0] w_p;    // bit propagate
   logic [15:0] w_c;    // carry into each bit
   logic [3:0]  w_gg;   // group generate
   logic [3:0]  w_gp;   // group propagate
   logic [3:0]  w_gc;   // carry into each group

   assign w_g = i_x & i_y;
   assign w_p = i_x ^ i_y;

   for (genvar j = 0; j < 4; j++) begin : g_grp
      assign w_gg[j] = w_g[4*j+3]
                     | (w_p[4*j+3] & w_g[4*j+2])
                     | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                     | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      assign w_gp[j] = &w_p[4*j +: 4];

      assign w_c[4*j]   = w_gc[j];
      assign w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
      assign w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                        | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
      assign w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                        | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                        | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
   end

   assign w_gc[0] = i_c0;
   assign w_gc[1] = w_gg[0] | (w_gp[0] & i_c0);
   assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_c0);
   assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & i_c0);

   assign o_g   = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
   assign o_p   = &w_gp;
   assign o_c16 = o_g | (o_p & i_c0);
   assign o_s   = w_p ^ w_c;

endmodule

module cla_wide_add_seq #(
   parameter  int N_WORDS = 4,
   localparam int W       = 16 * N_WORDS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         sub,
   input  logic         cin,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int KW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [KW-1:0]   r_k;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;       // already inverted for subtract
   logic            r_carry;
   logic [W-1:0]    r_sum;
   logic            r_cout;
   logic            r_ovf;

   logic [15:0]     w_x;
   logic [15:0]     w_y;
   logic [15:0]     w_s;
   logic            w_c16;
   logic            w_g_unused;
   logic            w_p_unused;
   logic            w_last;

   assign w_x    = r_a[16*r_k +: 16];
   assign w_y    = r_b[16*r_k +: 16];
   assign w_last = (r_k == KW'(N_WORDS - 1));

   Cla_16 u_cla (
      .i_x   (w_x),
      .i_y   (w_y),
      .i_c0  (r_carry),
      .o_s   (w_s),
      .o_c16 (w_c16),
      .o_g   (w_g_unused),
      .o_p   (w_p_unused)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  // a - b - cin == a + ~b + ~cin
                  r_carry <= cin ^ sub;
                  r_k     <= '0;
                  r_sum   <= '0;
               end
            end
            S_RUN: begin
               r_sum[16*r_k +: 16] <= w_s;
               r_carry             <= w_c16;
               r_k                 <= r_k + 1'b1;
               if (w_last) begin
                  r_cout <= w_c16;
                  // carry into the MSB differs from carry out of it
                  r_ovf  <= w_s[15] ^ w_x[15] ^ w_y[15] ^ w_c16;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
module tb_cla_wide_add_seq;

   localparam int N = 4;
   localparam int W = 16 * N;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_checks = 0;
   int n_pass   = 0;

   cla_wide_add_seq #(.N_WORDS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .cin   (cin),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // phase 0 = idle, 1..N = slice cycles, N+1 = done cycle
   int           m_phase = 0;
   bit           m_init  = 0;
   logic [W-1:0] m_sum, p_sum;
   logic         m_cout, m_ovf, p_cout, p_ovf;

   // Result from plain integer arithmetic on widened operands.
   task automatic model_op(input logic [W-1:0] ia, ib, input logic isub, icin,
                           output logic [W-1:0] osum, output logic ocout, oovf);
      logic        [W+1:0] ua, ub, uc, ur;
      logic signed [W+1:0] sa, sb, sc, sr, smax, smin;
      ua = {2'b00, ia};
      ub = {2'b00, ib};
      uc = {{(W+1){1'b0}}, icin};
      sa = {{2{ia[W-1]}}, ia};
      sb = {{2{ib[W-1]}}, ib};
      sc = {{(W+1){1'b0}}, icin};
      smax = {3'b000, {(W-1){1'b1}}};
      smin = -smax - 1;
      if (isub) begin
         ur    = ua - ub - uc;
         ocout = (ua >= ub + uc);
         sr    = sa - sb - sc;
      end else begin
         ur    = ua + ub + uc;
         ocout = ur[W];
         sr    = sa + sb + sc;
      end
      osum = ur[W-1:0];
      oovf = (sr > smax) || (sr < smin);
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0;
         m_sum   = '0;
         m_cout  = 1'b0;
         m_ovf   = 1'b0;
         m_init  = 1;
      end else if (m_phase == 0) begin
         if (start) begin
            model_op(a, b, sub, cin, p_sum, p_cout, p_ovf);
            m_phase = 1;
         end
      end else if (m_phase < N) begin
         m_phase++;
      end else if (m_phase == N) begin
         m_phase = N + 1;
         m_sum   = p_sum;
         m_cout  = p_cout;
         m_ovf   = p_ovf;
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("m_busy", W'(busy), W'(m_phase != 0));
         chk("m_done", W'(done), W'(m_phase == N + 1));
         chk("m_cout", W'(cout), W'(m_cout));
         chk("m_ovf",  W'(ovf),  W'(m_ovf));
         if (m_phase == 0 || m_phase == N + 1) chk("m_sum", sum, m_sum);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_done(input string name);
      int n;
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, W'(n), W'(N + 1));
   endtask

   task automatic run_op(input string name, input logic [W-1:0] ia, ib, input logic isub, icin,
                         input logic [W-1:0] esum, input logic ecout, eovf);
      @(negedge clk);
      a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
      @(negedge clk);
      // scramble inputs: in-flight operation must not see them
      start = 1'b0; a = ~ia; b = ~ib; sub = ~isub; cin = ~icin;
      wait_done(name);
      chk({name, "_sum"},  sum,      esum);
      chk({name, "_cout"}, W'(cout), W'(ecout));
      chk({name, "_ovf"},  W'(ovf),  W'(eovf));
   endtask

   initial begin
      int ndone;
      reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_sum",  sum,      '0);
      chk("rst_cout", W'(cout), '0);
      chk("rst_ovf",  W'(ovf),  '0);
      reset = 1'b0;

      run_op("t1_add",   64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
      run_op("t2_ripple",64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      run_op("t3_povf",  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run_op("t3_novf",  64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      run_op("t4_sub",   64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0);
      run_op("t4_neg",   64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      run_op("t4_borrow",64'h7, 64'h5, 1'b1, 1'b1, 64'h1, 1'b1, 1'b0);
      run_op("x_mix",    64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      run_op("x_cin",    64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1,
             64'h0, 1'b1, 1'b0);

      // start held high through RUN and DONE
      @(negedge clk);
      a = 64'h0000_0000_0000_FFFF; b = 64'h1; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 64'h7; b = 64'h5; sub = 1'b1; cin = 1'b0;
      wait_done("t5_first");
      chk("t5_first_sum", sum, 64'h0000_0000_0001_0000);
      @(negedge clk);
      chk("t5_hold_busy", W'(busy), '0);
      chk("t5_hold_sum",  sum, 64'h0000_0000_0001_0000);
      @(negedge clk);
      start = 1'b0;
      chk("t5_accept_busy", W'(busy), W'(1));
      wait_done("t5_second");
      chk("t5_second_sum",  sum,      64'h2);
      chk("t5_second_cout", W'(cout), W'(1));

      // reset in the second RUN cycle
      @(negedge clk);
      a = 64'h0000_0000_0000_FFFF; b = 64'h1; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t6_busy", W'(busy), '0);
      chk("t6_done", W'(done), '0);
      chk("t6_sum",  sum,      '0);
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("t6_no_done", W'(ndone), '0);
      run_op("t6_again", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
